// File: rtl/seg_reader99_pkg.sv
// seg_reader99_pkg: segment codes, stability FSM states and default stability length.
package seg_reader99_pkg;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [9:0][6:0] SEG_CODES = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    typedef enum logic [1:0] {IDLE, WAIT_STABLE, HELD} state_t;
endpackage

// File: rtl/seg_reader99_seg7_to_bcd.sv
// seg7_to_bcd: active-high 7-segment pattern to BCD digit with a legal flag.
module seg7_to_bcd
    import seg_reader99_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] bcd,
    output logic       legal
);
    always_comb begin
        bcd   = 4'd0;
        legal = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pat == SEG_CODES[i]) begin
                bcd   = i[3:0];
                legal = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_reader99.sv
// seg_reader99: debounced two-digit 7-segment bus reader; define SEG_ACTIVE_LOW_EN for a common-anode bus.
module seg_reader99
    import seg_reader99_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       sel_in,
    output logic [3:0] unidades,
    output logic [3:0] decenas,
    output logic       valid,
    output logic       err
);
    logic [8:0] sync1, sync2;
    logic [6:0] pat;
    logic [7:0] key, prev, cnt, cnt_n;
    logic [3:0] bcd, stg_u, stg_t;
    logic [1:0] seen, seen_n;
    logic       legal, accept, publish, sel, unused_dp;
    state_t     state, state_n;

`ifdef SEG_ACTIVE_LOW_EN
    assign pat = ~sync2[6:0];
`else
    assign pat = sync2[6:0];
`endif
    assign sel       = sync2[8];
    assign unused_dp = sync2[7];
    assign key       = {sel, pat};
    assign publish   = &seen;

    seg7_to_bcd u_dec (.pat(pat), .bcd(bcd), .legal(legal));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                state_n = WAIT_STABLE;
                cnt_n   = 8'd1;
            end
            WAIT_STABLE: begin
                cnt_n = (key == prev) ? cnt + 8'd1 : 8'd1;
                if (key == prev && cnt_n == STABLE_CYCLES[7:0]) begin
                    accept  = 1'b1;
                    state_n = HELD;
                end
            end
            HELD: begin
                if (key != prev) begin
                    state_n = WAIT_STABLE;
                    cnt_n   = 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A publish clears the flags before this edge's acceptance can set one again
    always_comb begin
        seen_n = publish ? 2'b00 : seen;
        if (accept) seen_n[sel] = legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            cnt      <= '0;
            state    <= IDLE;
            seen     <= '0;
            stg_u    <= '0;
            stg_t    <= '0;
            unidades <= '0;
            decenas  <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            sync1 <= {sel_in, seg_in};
            sync2 <= sync1;
            prev  <= key;
            cnt   <= cnt_n;
            state <= state_n;
            seen  <= seen_n;
            valid <= publish;
            err   <= accept & ~legal;
            if (accept && legal && !sel) stg_u <= bcd;
            if (accept && legal && sel) stg_t <= bcd;
            if (publish) begin
                unidades <= stg_u;
                decenas  <= stg_t;
            end
        end
    end
endmodule

// File: doc/seg_reader99.md
SEG_READER99 -- requirements
Module: seg_reader99

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port seg_in, input, 8 bits: multiplexed segment bus {dp,g,f,e,d,c,b,a}, asynchronous to clk.
REQ-005 SHALL have port sel_in, input, 1 bit: digit select, 0 = units, 1 = tens, asynchronous to clk.
REQ-006 SHALL have port unidades, output, 4 bits: last accepted units digit in BCD.
REQ-007 SHALL have port decenas, output, 4 bits: last accepted tens digit in BCD.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle strobe when a new digit pair is published.
REQ-009 SHALL have port err, output, 1 bit: one-cycle strobe when an accepted pattern is not a legal digit.

Function
REQ-010 SHALL pass seg_in and sel_in through a 2-flop synchronizer before any other use; all following timing counts synchronized samples.
REQ-011 SHALL ignore dp (bit 7) in every comparison and in decoding.
REQ-012 SHALL decode active-high bits [6:0] as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); any other pattern is illegal.
REQ-013 SHALL use a stability FSM with three states: IDLE, WAIT_STABLE and HELD.
REQ-014 IDLE -> WAIT_STABLE on the first sample after reset; the counter loads to 1.
REQ-015 In WAIT_STABLE, when {sel,seg[6:0]} equals the previous sample, the counter SHALL increment; when it differs, the counter SHALL reload to 1 and the state is unchanged.
REQ-016 When the counter reaches STABLE_CYCLES, the digit SHALL be accepted on that edge and the FSM SHALL move to HELD.
REQ-017 HELD SHALL return to WAIT_STABLE (counter = 1) on any sample change; an unchanged sample SHALL never be accepted twice.
REQ-018 A legal accepted digit SHALL be written to the staging register selected by sel and SHALL set that digit's seen flag.
REQ-019 An illegal accepted pattern SHALL pulse err on the next cycle, SHALL clear the seen flag of that digit, and SHALL leave the staging registers unchanged.
REQ-020 When both seen flags are set, on the next cycle the block SHALL copy staging to unidades/decenas, pulse valid for exactly 1 cycle, and clear both flags.
REQ-021 The pair SHALL be published even when the value is unchanged; digit order (units or tens first) is irrelevant.
REQ-022 Repeated acceptance of the same digit before its partner SHALL overwrite the staging register; the latest value wins.
REQ-023 valid and err SHALL never be asserted in the same cycle, because an illegal acceptance cannot complete a pair.

Reset
REQ-024 While reset is high: unidades=0, decenas=0, valid=0, err=0, FSM=IDLE, counter=0, seen flags=0, synchronizer flops=0, staging registers=0.
REQ-025 Reset asserted mid-operation SHALL discard any partial pair; no valid may follow reset release until two fresh acceptances complete a pair.

Configuration
REQ-026 With SEG_ACTIVE_LOW_EN defined, seg_in[6:0] SHALL be inverted after synchronization, before comparison and decoding, so that a common-anode bus decodes with the REQ-012 table.
REQ-027 With SEG_ACTIVE_LOW_EN not defined, seg_in SHALL be used as-is (active-high).

Structure
REQ-028 The shared package SHALL hold the ten segment code constants, the FSM state typedef and the default for STABLE_CYCLES.
REQ-029 Decoding SHALL be a combinational sub-module seg7_to_bcd: 7-bit pattern in, 4-bit BCD plus legal flag out.

Verification
REQ-030 sel=0/seg=07 then sel=1/seg=66, each held 10 samples -> exactly one valid, with unidades=7 and decenas=4.
REQ-031 seg toggles every 3 samples with STABLE_CYCLES=4 -> no acceptance, no valid, no err.
REQ-032 sel=0/seg=49 held 10 samples -> one err pulse, no valid, staging unchanged.
REQ-033 units=3 (4F) accepted, then reset pulsed, then tens=9 (6F) accepted -> no valid; after units=3 is accepted again -> valid with 3/9.
REQ-034 seg=86 (dp set, pattern 1) followed by seg=06 -> treated as one continuous stable sample, so only one acceptance.
REQ-035 With SEG_ACTIVE_LOW_EN defined, units C0 and tens F9 -> valid with unidades=0 and decenas=1.
